// File: rtl/timer_scheduler_if.sv
// Request/grant bundle between requesters and the shared countdown timer.
interface timer_scheduler_if #(
   parameter int NREQ = 4,
   parameter int W    = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] load_val;
   logic              abort;
   logic [NREQ-1:0]   grant;
   logic              busy;
   logic [W-1:0]      count;
   logic [NREQ-1:0]   done;

   modport master (output req, load_val, abort, input grant, busy, count, done);
   modport slave  (input req, load_val, abort, output grant, busy, count, done);
endinterface

// File: rtl/timer_scheduler.sv
// Round-robin shared countdown timer: one requester at a time owns the
// counter, counts its load value down to zero, then gets a one-cycle done.
module timer_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   timer_scheduler_if.slave  bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   logic [1:0]      state;
   logic [PW-1:0]   ptr;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] done;
   logic [W-1:0]    count;

   logic [W-1:0]    lv_arr [NREQ];
   logic [PW-1:0]   cand;
   logic [PW-1:0]   win;
   logic            found;

   for (genvar i = 0; i < NREQ; i++) begin : g_lv
      assign lv_arr[i] = bus.load_val[i*W +: W];
   end

   // Search starts one past the last winner, so the previous owner goes last.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = PW'((int'(ptr) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         done  <= '0;
         count <= '0;
         ptr   <= PW'(NREQ - 1);
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  state <= RUN;
                  grant <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                  count <= lv_arr[win];
                  ptr   <= win;
               end
            end
            RUN: begin
               if (bus.abort) begin
                  state <= IDLE;
                  grant <= '0;
                  count <= '0;
               end else if (count != '0) begin
                  count <= count - 1'b1;
               end else begin
                  state <= FIN;
                  done  <= grant;
               end
            end
            FIN: begin
               state <= IDLE;
               grant <= '0;
               count <= '0;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               count <= '0;
            end
         endcase
      end
   end

   assign bus.grant = grant;
   assign bus.done  = done;
   assign bus.count = count;
   assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a job-timeline model.
module tb_timer_scheduler;
   localparam int NREQ = 4;
   localparam int W    = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   timer_scheduler_if #(.NREQ(NREQ), .W(W)) bus ();

   timer_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Model: a job is (owner, grant cycle, load value); outputs follow from elapsed time.
   int m_own = -1;
   int m_t0  = 0;
   int m_v   = 0;
   int m_ptr = NREQ - 1;
   int cyc   = 0;

   function automatic int lv_of(input int i);
      return int'((bus.load_val >> (i*W)) & 16'hF);
   endfunction

   function automatic void model_edge();
      cyc++;
      if (rst) begin
         m_own = -1;
         m_ptr = NREQ - 1;
      end else if (m_own < 0) begin
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (bus.req[c]) begin
               m_own = c;
               m_t0  = cyc;
               m_v   = lv_of(c);
               m_ptr = c;
               break;
            end
         end
      end else begin
         if (bus.abort || (cyc - 1 - m_t0) == m_v + 1) m_own = -1;
      end
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic fail_timeout(input string nm);
      checks++;
      failures++;
      $display("FAIL %s cyc=%0d timed out", nm, cyc);
   endtask

   task automatic step();
      int e;
      logic [31:0] eg, ed, ec, eb;
      @(posedge clk);
      model_edge();
      #1;
      e  = cyc - m_t0;
      eg = (m_own < 0) ? 32'd0 : (32'd1 << m_own);
      eb = (m_own < 0) ? 32'd0 : 32'd1;
      ec = (m_own < 0 || e > m_v) ? 32'd0 : 32'(m_v - e);
      ed = (m_own >= 0 && e == m_v + 1) ? eg : 32'd0;
      chk("m_grant", 32'(bus.grant), eg);
      chk("m_done",  32'(bus.done),  ed);
      chk("m_busy",  32'(bus.busy),  eb);
      chk("m_count", 32'(bus.count), ec);
   endtask

   task automatic set_lv(input int i, input int v);
      bus.load_val[i*W +: W] = v[W-1:0];
   endtask

   task automatic wait_grant(input string nm, input int max);
      int n = 0;
      while (bus.grant == '0 && n < max) begin
         step();
         n++;
      end
      if (bus.grant == '0) fail_timeout(nm);
   endtask

   task automatic wait_idle(input string nm, input int max);
      int n = 0;
      while ((bus.busy || bus.grant != '0) && n < max) begin
         step();
         n++;
      end
      if (bus.busy || bus.grant != '0) fail_timeout(nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d simulation did not finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g_val [8];
      int g_cyc [8];
      int d_cyc [8];
      int ng, nd, n;
      logic [NREQ-1:0] prev;

      rst = 1'b1;
      bus.req = 4'b1111;
      bus.abort = 1'b0;
      bus.load_val = 16'h3333;

      // Reset with all requests high, then fairness under constant load.
      step();
      step();
      chk("rst_grant", 32'(bus.grant), 32'h0);
      chk("rst_done",  32'(bus.done),  32'h0);
      chk("rst_busy",  32'(bus.busy),  32'h0);
      chk("rst_count", 32'(bus.count), 32'h0);
      rst = 1'b0;
      step();
      chk("first_grant", 32'(bus.grant), 32'h1);
      ng = 1; nd = 0;
      g_val[0] = int'(bus.grant); g_cyc[0] = 0;
      prev = bus.grant;
      for (int s = 1; s <= 29; s++) begin
         step();
         if (bus.grant != '0 && prev == '0 && ng < 8) begin
            g_val[ng] = int'(bus.grant); g_cyc[ng] = s; ng++;
         end
         if (bus.done != '0 && nd < 8) begin
            d_cyc[nd] = s; nd++;
         end
         prev = bus.grant;
      end
      chk("fair_ngrants", 32'(ng), 32'd5);
      chk("fair_ndones",  32'(nd), 32'd5);
      if (ng == 5 && nd == 5) begin
         chk("fair_g1", 32'(g_val[1]), 32'h2);
         chk("fair_g2", 32'(g_val[2]), 32'h4);
         chk("fair_g3", 32'(g_val[3]), 32'h8);
         chk("fair_g4", 32'(g_val[4]), 32'h1);
         for (int j = 0; j < 5; j++) chk("fair_lat", 32'(d_cyc[j] - g_cyc[j]), 32'd4);
         for (int j = 1; j < 5; j++) chk("fair_gap", 32'(g_cyc[j] - d_cyc[j-1]), 32'd2);
      end
      bus.req = '0;
      wait_idle("fair_idle", 10);

      // Single job on requester 2 with load 5; later req/load_val changes ignored.
      bus.req = 4'b0100;
      bus.load_val = 16'h0500;
      wait_grant("single_grant", 4);
      chk("single_g", 32'(bus.grant), 32'h4);
      chk("single_c5", 32'(bus.count), 32'd5);
      bus.req = 4'b1011;
      for (int k = 4; k >= 0; k--) begin
         bus.load_val = 16'(($urandom() & 32'hFFFF));
         step();
         chk("single_cnt", 32'(bus.count), 32'(k));
         chk("single_nodone", 32'(bus.done), 32'h0);
      end
      step();
      chk("single_done", 32'(bus.done), 32'h4);
      chk("single_busy", 32'(bus.busy), 32'h1);
      bus.req = '0;
      step();
      chk("single_gclr", 32'(bus.grant), 32'h0);
      wait_idle("single_idle", 10);

      // Zero load value on requester 1.
      bus.req = 4'b0010;
      bus.load_val = 16'hFF0F;
      wait_grant("zero_grant", 4);
      chk("zero_g", 32'(bus.grant), 32'h2);
      chk("zero_c", 32'(bus.count), 32'h0);
      bus.req = '0;
      step();
      chk("zero_done", 32'(bus.done), 32'h2);
      chk("zero_c2", 32'(bus.count), 32'h0);
      step();
      chk("zero_gclr", 32'(bus.grant), 32'h0);
      wait_idle("zero_idle", 10);

      // Abort mid-count; the aborted winner keeps the pointer.
      bus.req = 4'b0001;
      bus.load_val = 16'h0009;
      wait_grant("abort_grant", 4);
      chk("abort_c9", 32'(bus.count), 32'd9);
      n = 0;
      while (bus.count != 4'd4 && n < 12) begin step(); n++; end
      if (bus.count != 4'd4) fail_timeout("abort_wait4");
      bus.abort = 1'b1;
      bus.req = 4'b0011;
      step();
      bus.abort = 1'b0;
      chk("abort_grant0", 32'(bus.grant), 32'h0);
      chk("abort_count0", 32'(bus.count), 32'h0);
      chk("abort_busy0",  32'(bus.busy),  32'h0);
      chk("abort_done0",  32'(bus.done),  32'h0);
      step();
      chk("abort_next", 32'(bus.grant), 32'h2);
      bus.req = '0;
      wait_idle("abort_idle", 40);

      // Reset in the middle of a job.
      bus.req = 4'b0001;
      bus.load_val = 16'h0006;
      wait_grant("mrst_grant", 4);
      n = 0;
      while (bus.count != 4'd2 && n < 12) begin step(); n++; end
      if (bus.count != 4'd2) fail_timeout("mrst_wait2");
      rst = 1'b1;
      bus.req = 4'b1000;
      step();
      rst = 1'b0;
      chk("mrst_grant0", 32'(bus.grant), 32'h0);
      chk("mrst_done0",  32'(bus.done),  32'h0);
      chk("mrst_busy0",  32'(bus.busy),  32'h0);
      chk("mrst_count0", 32'(bus.count), 32'h0);
      step();
      chk("mrst_next", 32'(bus.grant), 32'h8);
      bus.req = '0;
      wait_idle("mrst_idle", 40);

      // Randomized traffic, including aborts and resets in any state.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) bus.load_val = 16'($urandom() & 32'hFFFF);
         else bus.load_val = 16'($urandom() & 32'h3333);
         bus.abort = ($urandom_range(0, 24) == 0);
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      bus.abort = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
